// File: rtl/sfi_pkg.sv
// Shared SFI definitions: reject encoding, request field positions and word type.
package sfi_pkg;
  localparam int ADDR_HI = 63;
  localparam int ADDR_LO = 32;
  localparam logic [63:0] SFI_REJECT = 64'h0;

  typedef struct packed {
    logic [ADDR_HI-ADDR_LO:0] addr;
    logic [ADDR_LO-1:0]       data;
  } sfi_req_t;
endpackage

// File: rtl/sfi_fifo.sv
// Generic pointer FIFO; the pointer MSB is a wrap bit separating full from empty.
module sfi_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  parameter int PW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [PW-1:0] level
);
  logic [DEPTH-1:0][W-1:0] mem;
  logic [PW-1:0]           wr_ptr, rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]) && (wr_ptr[PW-1] != rd_ptr[PW-1]);
  assign level = wr_ptr - rd_ptr;
  // Head is masked so nothing stale leaks out while empty.
  assign rdata = empty ? '0 : mem[rd_ptr[PW-2:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[PW-2:0]] <= wdata;
  end
endmodule

// File: rtl/sfi_issue_queue.sv
// Issue stage after the SFI filter: drops rejected words as violations, queues the rest.
module sfi_issue_queue
  import sfi_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [63:0]              in_req,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_addr,
  output logic [31:0]              out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         viol_count,
  output logic                     viol_sticky,
  input  logic                     viol_clr
);
  logic     full, empty, accept, viol, push, pop;
  sfi_req_t head;

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign accept    = in_valid && in_ready;
  assign viol      = accept && (in_req == SFI_REJECT);
  assign push      = accept && !viol;
  assign pop       = out_valid && out_ready;
  assign out_addr  = head.addr;
  assign out_data  = head.data;

  sfi_fifo #(.DEPTH(DEPTH), .W(64)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (in_req),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // Clear takes effect before a same-cycle violation is counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      viol_count  <= '0;
      viol_sticky <= 1'b0;
    end else if (viol_clr) begin
      viol_count  <= viol ? CNT_W'(1) : '0;
      viol_sticky <= viol;
    end else if (viol) begin
      if (viol_count != '1) viol_count <= viol_count + 1'b1;
      viol_sticky <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sfi_issue_queue.sv
// Directed bench for sfi_issue_queue (CNT_W reduced to 4 to reach saturation quickly).
module tb_sfi_issue_queue;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, viol_sticky, viol_clr;
  logic [63:0] in_req;
  logic [31:0] out_addr, out_data;
  logic [2:0]  level;
  logic [CNT_W-1:0] viol_count;

  int n_tests = 0;
  int n_fail  = 0;

  sfi_issue_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_req(in_req),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
    .level(level), .viol_count(viol_count), .viol_sticky(viol_sticky), .viol_clr(viol_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] w [5];

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_req = '0; out_ready = 1'b0; viol_clr = 1'b0;
    w[0] = 64'h00000010_11111111;
    w[1] = 64'h00000000_00000001;  // address 0, legal
    w[2] = 64'h00000030_33333333;
    w[3] = 64'hFFFFFFFF_00000000;
    w[4] = 64'h00000050_55555555;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_level", level, 0);
    chk("rst_viol_count", viol_count, 0);
    chk("rst_viol_sticky", viol_sticky, 0);
    rst = 1'b0;

    // single enqueue, visible one cycle later
    in_req = 64'hA2199872_00000000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("enq_out_valid", out_valid, 1);
    chk("enq_out_addr", out_addr, 32'hA2199872);
    chk("enq_out_data", out_data, 0);
    chk("enq_level", level, 1);

    // rejected word
    in_req = 64'h0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("viol_level", level, 1);
    chk("viol_count", viol_count, 1);
    chk("viol_sticky", viol_sticky, 1);
    viol_clr = 1'b1;
    tick();
    viol_clr = 1'b0;
    chk("clr_count", viol_count, 0);
    chk("clr_sticky", viol_sticky, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("drain_level", level, 0);
    chk("drain_out_addr", out_addr, 0);

    // fill to full, 5th word held
    for (int i = 0; i < 4; i++) begin
      in_req = w[i]; in_valid = 1'b1;
      tick();
    end
    chk("full_level", level, 4);
    chk("full_in_ready", in_ready, 0);
    in_req = w[4];
    tick();
    chk("held_level", level, 4);
    chk("held_head", {out_addr, out_data}, w[0]);
    out_ready = 1'b1;
    tick();
    chk("pop1_level", level, 3);
    chk("pop1_head", {out_addr, out_data}, w[1]);
    tick();  // pop w1, accept w4
    in_valid = 1'b0;
    chk("pop2_level", level, 3);
    for (int i = 2; i < 5; i++) begin
      chk($sformatf("order_%0d", i), {out_addr, out_data}, w[i]);
      tick();
    end
    chk("order_empty_level", level, 0);
    chk("order_empty_valid", out_valid, 0);
    out_ready = 1'b0;

    // steady stream at level 2 across many wraps
    for (int i = 0; i < 2; i++) begin
      in_req = {32'hC0000000 + 32'(i), 32'(i + 1)}; in_valid = 1'b1;
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_req = {32'hC0000000 + 32'(i + 2), 32'(i + 3)};
      chk($sformatf("stream_data_%0d", i), out_data, 32'(i + 1));
      chk($sformatf("stream_level_%0d", i), level, 2);
      tick();
    end
    chk("stream_tail_addr", out_addr, 32'hC0000014);
    // stop popping, add one entry and a violation -> level 3, count 1
    out_ready = 1'b0;
    in_req = 64'hDEAD0000_00000001;
    tick();
    in_req = 64'h0;
    tick();
    in_valid = 1'b0;
    chk("pre_rst_level", level, 3);
    chk("pre_rst_count", viol_count, 1);

    // asynchronous reset between edges
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_level", level, 0);
    chk("arst_viol_count", viol_count, 0);
    chk("arst_sticky", viol_sticky, 0);
    #2 rst = 1'b0;
    in_req = 64'h12345678_9ABCDEF0; in_valid = 1'b1;
    tick();
    in_req = 64'h22222222_33333333;
    tick();
    in_valid = 1'b0;
    chk("post_rst_head", {out_addr, out_data}, 64'h12345678_9ABCDEF0);
    chk("post_rst_level", level, 2);

    // saturation of the violation counter
    in_req = 64'h0; in_valid = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    chk("sat_reach", viol_count, 4'hF);
    tick();
    chk("sat_hold", viol_count, 4'hF);
    chk("sat_level", level, 2);
    viol_clr = 1'b1;
    tick();
    viol_clr = 1'b0; in_valid = 1'b0;
    chk("clr_and_viol_count", viol_count, 1);
    chk("clr_and_viol_sticky", viol_sticky, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sfi_issue_queue.md
# sfi_issue_queue

Buffered issue stage directly downstream of the SFI address-sandboxing filter. It takes the filter's 64-bit request word (`{eff_addr[31:0], data[31:0]}`), which is all-zero when the filter rejected the effective address. It drops rejected words and counts them as isolation violations, and queues accepted requests in a small FIFO. Queued requests are issued to the memory side over a valid/ready handshake.

## Interface
- `DEPTH`, 4, FIFO entries; power of two, ≥2
- `CNT_W`, 16, width of the violation counter
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  upstream word on `in_req` is valid
- `in_ready`  out  1  stage can accept a word this cycle
- `in_req`  in  64  SFI output word; `[63:32]` effective address, `[31:0]` data; `64'h0` = rejected
- `out_valid`  out  1  head entry valid
- `out_ready`  in  1  memory side takes head this cycle
- `out_addr`  out  32  head `[63:32]`
- `out_data`  out  32  head `[31:0]`
- `level`  out  $clog2(DEPTH)+1  current occupancy
- `viol_count`  out  CNT_W  rejected words seen, saturating
- `viol_sticky`  out  1  set on any rejection; held until cleared
- `viol_clr`  in  1  synchronous clear of `viol_count` and `viol_sticky`

## Operation
- Reset values: `in_ready`=1, `out_valid`=0, `out_addr`=0, `out_data`=0, `level`=0, `viol_count`=0, `viol_sticky`=0.
- Reset mid-operation discards all queued entries. The pointers and all outputs return to their reset values immediately, asynchronously.
- Accept condition: `in_valid && in_ready`.
- Accepted word equal to `64'h0` is a violation. It is not enqueued and `level` is unchanged. `viol_count` increments, saturating at all-ones. `viol_sticky` is set.
- An accepted non-zero word is written at the write pointer. The pointer advances.
- Only the exact value `64'h0` counts as rejected. Address `0` with non-zero data is a legal request and is enqueued.
- `in_ready` = `level != DEPTH`. It is not combinationally dependent on `out_ready`, so a full queue does not accept a word even when popping in the same cycle.
- `in_ready` is also 1 when full if `in_req` is zero? No: `in_ready` depends only on `level`. A rejected word presented while full waits like any other.
- Pop condition: `out_valid && out_ready`. The read pointer advances.
- `out_valid` = `level != 0`. `out_addr`/`out_data` reflect the head entry. They are 0 when empty.
- Simultaneous push and pop: `level` is unchanged and both pointers advance.
- Pointers are `$clog2(DEPTH)+1` bits wide, and the MSB is the wrap bit. Full = indices equal and wrap bits differ. Empty = pointers equal. Wrap-around must be seamless across any number of cycles.
- `viol_clr` together with a violation in the same cycle: the result is `viol_count`=1 and `viol_sticky`=1, because the clear applies first.
- Upstream must hold `in_req` stable while `in_valid && !in_ready`. Downstream sees a stable head while `out_valid && !out_ready`.

## Timing
- Enqueue to `out_valid`: 1 cycle. A word accepted at edge N is visible on `out_*` after edge N. There is no same-cycle bypass.
- `level`, `viol_count` and `viol_sticky` update on the edge of the accepting or popping cycle.
- Throughput: one push and one pop per cycle, sustained while `0 < level < DEPTH`.
- All outputs come from registers or from the storage read mux. There is no combinational in→out path.

## Structure
- Shared package `sfi_pkg` holds these items, reused by the SFI filter:
  - `SFI_REJECT` = `64'h0`
  - the field slice positions (`ADDR_HI`=63, `ADDR_LO`=32)
  - the request word typedef
- One sub-module is natural: `sfi_fifo`. It is a generic DEPTH×64 pointer FIFO providing `full`/`empty`/`level`.
- The top level adds the reject filter, the violation counter and the sticky flag.

## Test plan
- Reset, then `in_req=64'hA219987200000000`, `in_valid=1` for one cycle, `out_ready=0` → next cycle `out_valid=1`, `out_addr=32'hA2199872`, `out_data=0`, `level=1`.
- `in_req=64'h0` accepted → nothing enqueued, `level` unchanged, `viol_count=1`, `viol_sticky=1`. Then pulse `viol_clr` → both 0.
- `out_ready=0`, push 4 distinct non-zero words → `level=4`, `in_ready=0`. A 5th word is held and not lost. Raise `out_ready` → the words pop in order, and the 5th is accepted on the cycle after the first pop.
- Hold `level=2` with `in_valid=out_ready=1` for 20 cycles of incrementing data → `level` stays 2, outputs in order, the pointers wrap with no loss or duplication.
- Assert `rst` asynchronously between edges with `level=3` → `out_valid=0`, `level=0`, `viol_count=0` at once. After release, the first new word is the first one output.
- Preload `viol_count` to all-ones by repeated zero words, then send one more → the count stays all-ones. Then drive `viol_clr` and a zero word in the same cycle → `viol_count=1`.
